// File: rtl/fb_arb_pkg.sv
// Shared constants for the framebuffer RAM arbiter: default geometry,
// requestor-index width and write-entry field layout.
package fb_arb_pkg;

  localparam int FB_DW_DEF  = 16;
  localparam int FB_AW_DEF  = 16;
  localparam int FB_NRD_DEF = 2;

  // Requestor index covers the write port (0) plus NRD read channels.
  function automatic int req_idx_w(input int nrd);
    return (nrd + 1 > 1) ? $clog2(nrd + 1) : 1;
  endfunction

  localparam int FB_REQ_IW_DEF = $clog2(FB_NRD_DEF + 1);

  // Write entry layout: {addr, data}; data sits at the bottom and the
  // address starts right above it (offset equals the data width).
  localparam int WR_DATA_LSB = 0;

  function automatic int wr_addr_lsb(input int dw);
    return WR_DATA_LSB + dw;
  endfunction

endpackage

// File: rtl/fb_arb_pick.sv
// Single-grant picker over the write port and NRD read channels.
// FB_ARB_RR_EN defined: round-robin starting at rr_ptr.
// FB_ARB_RR_EN undefined: fixed priority, index 0 (write) highest.
module fb_arb_pick
  import fb_arb_pkg::*;
#(
  parameter int NRD = FB_NRD_DEF,
  parameter int IW  = req_idx_w(NRD)
) (
  input  logic [NRD:0]  elig,
`ifdef FB_ARB_RR_EN
  input  logic [IW-1:0] rr_ptr,
`endif
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx
);

  localparam logic [IW:0] NREQ = (IW+1)'(NRD + 1);

  logic [IW-1:0] start;
  logic [IW:0]   cand;

`ifdef FB_ARB_RR_EN
  assign start = rr_ptr;
`else
  assign start = '0;
`endif

  // Scan requestors from start, wrapping modulo NRD+1; first eligible wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k <= NRD; k++) begin
      cand = {1'b0, start} + (IW+1)'(k);
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      if (!grant_valid && elig[cand[IW-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fb_ram_arbiter.sv
// Framebuffer frame store shared by one write stream and NRD read channels.
// One memory access per cycle; reads return one cycle after the pop into the
// channel's return FIFO. Build option FB_ARB_RR_EN selects round-robin
// arbitration; otherwise fixed priority (write first, then ch0, ch1, ...).
module fb_ram_arbiter
  import fb_arb_pkg::*;
#(
  parameter int DW  = FB_DW_DEF,
  parameter int AW  = FB_AW_DEF,
  parameter int NRD = FB_NRD_DEF
) (
  input  logic                clk,
  input  logic                rst,
  output logic                wr_in_ren,
  input  logic [AW+DW-1:0]    wr_in_rd,
  input  logic                wr_in_empty,
  output logic [NRD-1:0]      addr_in_ren,
  input  logic [NRD*AW-1:0]   addr_in_rd,
  input  logic [NRD-1:0]      addr_in_empty,
  output logic [NRD-1:0]      data_out_wen,
  output logic [NRD*DW-1:0]   data_out_wd,
  input  logic [NRD-1:0]      data_out_full
);

  localparam int IW    = req_idx_w(NRD);
  localparam int DEPTH = 1 << AW;
  localparam int WA_LSB = wr_addr_lsb(DW);

  logic [NRD:0]    elig_p0;
  logic            gnt_raw_p0;
  logic            gnt_vld_p0;
  logic [IW-1:0]   gnt_idx_p0;
  logic [AW-1:0]   rd_addr_p0;

  logic            inflight_v;
  logic [IW-1:0]   inflight_id;
  logic [DW-1:0]   rd_data_p1;
  logic [NRD-1:0]  wen_p1;
  logic [DW-1:0]   wd_hold [NRD];

  logic [DW-1:0]   mem [DEPTH];

`ifdef FB_ARB_RR_EN
  logic [IW-1:0]   rr_ptr;
`endif

  // ---- stage p0: eligibility, grant and FIFO pops ----

  // Requestor eligibility; a channel with a read in flight sits out one cycle.
  always_comb begin
    elig_p0    = '0;
    elig_p0[0] = !wr_in_empty;
    for (int i = 0; i < NRD; i++) begin
      elig_p0[i+1] = !addr_in_empty[i] && !data_out_full[i] &&
                     !(inflight_v && (inflight_id == IW'(i)));
    end
  end

  fb_arb_pick #(
    .NRD (NRD),
    .IW  (IW)
  ) u_pick (
    .elig        (elig_p0),
`ifdef FB_ARB_RR_EN
    .rr_ptr      (rr_ptr),
`endif
    .grant_valid (gnt_raw_p0),
    .grant_idx   (gnt_idx_p0)
  );

  assign gnt_vld_p0 = gnt_raw_p0 && !rst;

  // Pop strobes follow the grant directly; nothing pops during reset.
  always_comb begin
    wr_in_ren   = gnt_vld_p0 && (gnt_idx_p0 == '0);
    addr_in_ren = '0;
    for (int i = 0; i < NRD; i++) begin
      addr_in_ren[i] = gnt_vld_p0 && (gnt_idx_p0 == IW'(i + 1));
    end
  end

  // Select the read address of the granted channel.
  always_comb begin
    rd_addr_p0 = '0;
    for (int i = 0; i < NRD; i++) begin
      if (gnt_idx_p0 == IW'(i + 1)) begin
        rd_addr_p0 = addr_in_rd[i*AW +: AW];
      end
    end
  end

  // Single-port frame store with registered read; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_in_ren) begin
      mem[wr_in_rd[WA_LSB +: AW]] <= wr_in_rd[WR_DATA_LSB +: DW];
    end
    if (|addr_in_ren) begin
      rd_data_p1 <= mem[rd_addr_p0];
    end
  end

`ifdef FB_ARB_RR_EN
  // Round-robin pointer moves just past the granted requestor.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (gnt_vld_p0) begin
      rr_ptr <= (gnt_idx_p0 == IW'(NRD)) ? '0 : gnt_idx_p0 + IW'(1);
    end
  end
`endif

  // ---- stage p1: read return into the channel's data FIFO ----

  // Track the single outstanding read and its channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_v  <= 1'b0;
      inflight_id <= '0;
    end else begin
      inflight_v  <= |addr_in_ren;
      inflight_id <= gnt_idx_p0 - IW'(1);
    end
  end

  // Push strobe for the returning channel; a read in flight at reset is dropped.
  always_comb begin
    wen_p1 = '0;
    for (int i = 0; i < NRD; i++) begin
      wen_p1[i] = inflight_v && !rst && (inflight_id == IW'(i));
    end
  end

  assign data_out_wen = wen_p1;

  // Each channel keeps its last returned word while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NRD; i++) begin
        wd_hold[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NRD; i++) begin
        if (wen_p1[i]) begin
          wd_hold[i] <= rd_data_p1;
        end
      end
    end
  end

  // Present fresh read data on the returning channel, held data elsewhere.
  always_comb begin
    data_out_wd = '0;
    for (int i = 0; i < NRD; i++) begin
      data_out_wd[i*DW +: DW] = wen_p1[i] ? rd_data_p1 : wd_hold[i];
    end
  end

endmodule

// File: tb/tb_fb_ram_arbiter.sv
// Bench for fb_ram_arbiter: queue-backed FIFOs, a transaction-level reference
// model of the arbitration rules and frame store, directed scenarios and a
// randomized phase. Honours FB_ARB_RR_EN when the DUT is built with it.
module tb_fb_ram_arbiter;

  localparam int DW  = 16;
  localparam int AW  = 16;
  localparam int NRD = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                wr_in_ren;
  logic [AW+DW-1:0]    wr_in_rd = '0;
  logic                wr_in_empty = 1'b1;
  logic [NRD-1:0]      addr_in_ren;
  logic [NRD*AW-1:0]   addr_in_rd = '0;
  logic [NRD-1:0]      addr_in_empty = '1;
  logic [NRD-1:0]      data_out_wen;
  logic [NRD*DW-1:0]   data_out_wd;
  logic [NRD-1:0]      data_out_full = '0;

  fb_ram_arbiter #(.DW(DW), .AW(AW), .NRD(NRD)) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_in_ren     (wr_in_ren),
    .wr_in_rd      (wr_in_rd),
    .wr_in_empty   (wr_in_empty),
    .addr_in_ren   (addr_in_ren),
    .addr_in_rd    (addr_in_rd),
    .addr_in_empty (addr_in_empty),
    .data_out_wen  (data_out_wen),
    .data_out_wd   (data_out_wd),
    .data_out_full (data_out_full)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // FIFO contents and return-FIFO full flags seen by the DUT
  typedef logic [AW-1:0] addr_q_t [$];
  logic [AW+DW-1:0] wq [$];
  addr_q_t          aq [NRD];
  logic [NRD-1:0]   full_v = '0;

  // Reference model state
  logic [DW-1:0]    mmem [logic [AW-1:0]];
  bit               m_infl_v = 0;
  int               m_infl_id = 0;
  logic [DW-1:0]    m_rd = '0;
  logic [DW-1:0]    m_last [NRD];
  int               m_rr = 0;

  // Observations from the most recent step
  logic             obs_wr_ren;
  logic [NRD-1:0]   obs_ren;
  logic [NRD-1:0]   obs_wen;
  logic [NRD*DW-1:0] obs_wd;
  int               grant_log [$];

  logic [AW-1:0]    pool [16];

  function automatic int model_pick(input logic [NRD:0] el);
    int start;
    start = 0;
`ifdef FB_ARB_RR_EN
    start = m_rr;
`endif
    for (int k = 0; k <= NRD; k++) begin
      int idx;
      idx = (start + k) % (NRD + 1);
      if (el[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic drive();
    wr_in_empty = (wq.size() == 0);
    wr_in_rd    = (wq.size() != 0) ? wq[0] : '0;
    for (int i = 0; i < NRD; i++) begin
      addr_in_empty[i]       = (aq[i].size() == 0);
      addr_in_rd[i*AW +: AW] = (aq[i].size() != 0) ? aq[i][0] : '0;
    end
    data_out_full = full_v;
  endtask

  // One clock cycle: drive, compare at the falling edge, advance the model.
  task automatic step();
    logic [NRD:0]      el;
    int                g;
    logic              e_wr_ren;
    logic [NRD-1:0]    e_ren;
    logic [NRD-1:0]    e_wen;
    logic [NRD*DW-1:0] e_wd;
    logic [AW+DW-1:0]  ent;
    logic [AW-1:0]     a;
    drive();
    @(negedge clk);
    el    = '0;
    el[0] = (wq.size() != 0);
    for (int i = 0; i < NRD; i++) begin
      el[i+1] = (aq[i].size() != 0) && !full_v[i] && !(m_infl_v && m_infl_id == i);
    end
    g = rst ? -1 : model_pick(el);
    e_wr_ren = (g == 0);
    for (int i = 0; i < NRD; i++) begin
      e_ren[i] = (g == i + 1);
      e_wen[i] = !rst && m_infl_v && (m_infl_id == i);
      e_wd[i*DW +: DW] = e_wen[i] ? m_rd : m_last[i];
    end
    obs_wr_ren = wr_in_ren;
    obs_ren    = addr_in_ren;
    obs_wen    = data_out_wen;
    obs_wd     = data_out_wd;
    check_eq("wr_in_ren", 64'(wr_in_ren), 64'(e_wr_ren));
    check_eq("addr_in_ren", 64'(addr_in_ren), 64'(e_ren));
    check_eq("data_out_wen", 64'(data_out_wen), 64'(e_wen));
    check_eq("data_out_wd", 64'(data_out_wd), 64'(e_wd));
    grant_log.push_back(g);
    @(posedge clk);
    if (rst) begin
      m_infl_v = 0;
      m_rr     = 0;
      for (int i = 0; i < NRD; i++) m_last[i] = '0;
    end else begin
      for (int i = 0; i < NRD; i++) if (e_wen[i]) m_last[i] = m_rd;
      m_infl_v = 0;
      if (g == 0) begin
        ent = wq.pop_front();
        mmem[ent[AW+DW-1:DW]] = ent[DW-1:0];
      end else if (g > 0) begin
        a         = aq[g-1].pop_front();
        m_rd      = mmem[a];
        m_infl_v  = 1;
        m_infl_id = g - 1;
      end
      if (g >= 0) m_rr = (g + 1) % (NRD + 1);
    end
    #1;
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wq.push_back({a, d});
  endtask

  task automatic push_rd(input int ch, input logic [AW-1:0] a);
    aq[ch].push_back(a);
  endtask

  function automatic bit busy();
    bit b;
    b = (wq.size() != 0) || m_infl_v;
    for (int i = 0; i < NRD; i++) b = b || (aq[i].size() != 0);
    return b;
  endfunction

  task automatic drain(input string tag);
    full_v = '0;
    for (int n = 0; n < 200 && busy(); n++) step();
    step();
    check_eq(tag, 64'(busy()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    logic [5:0] pat;
    int exp_seq [6];
    for (int i = 0; i < NRD; i++) m_last[i] = '0;
    drive();
    @(posedge clk);
    #1;

    // Reset held: no pops, no pushes, outputs zero
    for (int n = 0; n < 3; n++) step();
    check_eq("reset_wd_zero", 64'(obs_wd), 64'(0));
    rst = 1'b0;

    // Write then readback on ch0
    push_wr(16'h0010, 16'hBEEF);
    step();
    check_eq("wb_write_pop", 64'(obs_wr_ren), 64'(1));
    push_rd(0, 16'h0010);
    step();
    check_eq("wb_read_pop", 64'(obs_ren[0]), 64'(1));
    step();
    check_eq("wb_return_wen", 64'(obs_wen[0]), 64'(1));
    check_eq("wb_return_data", 64'(obs_wd[15:0]), 64'h BEEF);

    // Write at t, ch1 reads the same word at t+1
    push_wr(16'h0005, 16'h1234);
    step();
    push_rd(1, 16'h0005);
    step();
    check_eq("wr_rd_pop", 64'(obs_ren[1]), 64'(1));
    step();
    check_eq("wr_rd_data", 64'(obs_wd[31:16]), 64'h1234);

    // Backpressure on ch1 for ten cycles
    full_v[1] = 1'b1;
    push_rd(1, 16'h0010);
    cnt = 0;
    for (int n = 0; n < 10; n++) begin
      step();
      cnt += int'(obs_ren[1]);
    end
    check_eq("bp_no_pop", 64'(cnt), 64'(0));
    full_v[1] = 1'b0;
    step();
    check_eq("bp_release_pop", 64'(obs_ren[1]), 64'(1));
    full_v[1] = 1'b1;
    step();
    check_eq("bp_inflight_wen", 64'(obs_wen[1]), 64'(1));
    check_eq("bp_inflight_data", 64'(obs_wd[31:16]), 64'h BEEF);
    full_v[1] = 1'b0;

    // Only one read per channel in flight
    push_rd(0, 16'h0005);
    push_rd(0, 16'h0010);
    push_rd(0, 16'h0005);
    pat = '0;
    for (int n = 0; n < 6; n++) begin
      step();
      pat[n] = obs_ren[0];
    end
    check_eq("single_inflight_pattern", 64'(pat), 64'b010101);

    // Fill an address pool, including the lowest and highest addresses
    pool[0] = '0;
    pool[1] = '1;
    for (int k = 2; k < 16; k++) pool[k] = AW'($urandom);
    for (int k = 0; k < 16; k++) push_wr(pool[k], DW'($urandom));
    drain("fill_drained");

    // Randomized traffic with random return-FIFO backpressure
    for (int n = 0; n < 600; n++) begin
      if (wq.size() < 4 && $urandom_range(0, 2) == 0)
        push_wr(pool[$urandom_range(0, 15)], DW'($urandom));
      for (int i = 0; i < NRD; i++) begin
        if (aq[i].size() < 4 && $urandom_range(0, 1) == 1)
          push_rd(i, pool[$urandom_range(0, 15)]);
        full_v[i] = ($urandom_range(0, 3) == 0);
      end
      step();
    end
    drain("random_drained");

    // Reset one cycle after a ch0 grant discards the read
    push_rd(0, pool[3]);
    step();
    check_eq("rst_pre_grant", 64'(obs_ren[0]), 64'(1));
    rst = 1'b1;
    step();
    check_eq("rst_no_wen", 64'(obs_wen), 64'(0));
    rst = 1'b0;
    step();
    check_eq("rst_after_wd", 64'(obs_wd), 64'(0));

    // Saturated requestors straight after reset
    grant_log.delete();
    for (int k = 0; k < 6; k++) begin
      push_wr(pool[k], DW'($urandom));
      push_rd(0, pool[k]);
      push_rd(1, pool[k + 6]);
    end
`ifdef FB_ARB_RR_EN
    exp_seq = '{0, 1, 2, 0, 1, 2};
`else
    exp_seq = '{0, 0, 0, 0, 0, 0};
`endif
    for (int n = 0; n < 6; n++) step();
    for (int n = 0; n < 6; n++) check_eq("arb_seq", 64'(grant_log[n]), 64'(exp_seq[n]));
    drain("sat_drained");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
